// File: rtl/gb_cpu_common_pkg.sv
// Shared definitions for the Game Boy CPU interrupt controller: scheduler states,
// ISR vector constants and dispatch timing.
package gb_cpu_common_pkg;

   typedef enum logic [1:0] {
      StRun,
      StHalt,
      StDispatch
   } irq_state_e;

   localparam logic [7:0] VEC_VBLANK   = 8'h40;
   localparam logic [7:0] VEC_LCD_STAT = 8'h48;
   localparam logic [7:0] VEC_TIMER    = 8'h50;
   localparam logic [7:0] VEC_SERIAL   = 8'h58;
   localparam logic [7:0] VEC_JOYPAD   = 8'h60;

   localparam logic [2:0] IsrCycles     = 3'd5;
   localparam logic [2:0] IsrClearCycle = 3'd4;

   function automatic logic [7:0] isr_vector(input logic [2:0] idx);
      logic [7:0] vec;
      case (idx)
         3'd0:    vec = VEC_VBLANK;
         3'd1:    vec = VEC_LCD_STAT;
         3'd2:    vec = VEC_TIMER;
         3'd3:    vec = VEC_SERIAL;
         3'd4:    vec = VEC_JOYPAD;
         default: vec = 8'h00;
      endcase
      return vec;
   endfunction

endpackage

// File: rtl/gb_cpu_irq_priority.sv
// Fixed-priority interrupt resolver: lowest pending bit wins.
module gb_cpu_irq_priority (
   input  logic [4:0] pending_i,
   output logic [4:0] onehot_o,
   output logic [2:0] index_o,
   output logic       valid_o
);

   always_comb begin
      onehot_o = pending_i & (~pending_i + 5'd1);
      valid_o  = |pending_i;
      index_o  = 3'd0;
      for (int i = 4; i >= 0; i--) begin
         if (pending_i[i]) index_o = 3'(i);
      end
   end

endmodule

// File: rtl/gb_cpu_interrupt_ctrl.sv
// Game Boy CPU interrupt controller: IME/EI delay, HALT handling and the 5-cycle ISR dispatch.
// Define GB_CPU_ISR_CANCEL_EN to re-resolve the serviced interrupt in dispatch cycle 4.
module gb_cpu_interrupt_ctrl
   import gb_cpu_common_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       boundary_i,
   input  logic       ei_i,
   input  logic       di_i,
   input  logic       reti_i,
   input  logic       halt_i,
   input  logic [4:0] ie_i,
   input  logic [4:0] if_i,
   output logic       ime_o,
   output logic       dispatch_o,
   output logic [2:0] dispatch_cycle_o,
   output logic [7:0] isr_vector_o,
   output logic [4:0] if_clear_o,
   output logic       halted_o,
   output logic       halt_bug_o
);

   irq_state_e state_q, state_d;
   logic [2:0] cnt_q, cnt_d;
   logic       ime_q, ime_d;
   logic       ime_delay_q, ime_delay_d;
   logic       halt_bug_q, halt_bug_d;
   logic [2:0] vec_idx_q, vec_idx_d;
   logic [4:0] vec_oh_q, vec_oh_d;
   logic       vec_valid_q, vec_valid_d;

   logic [4:0] pending;
   logic [4:0] irq_oh;
   logic [2:0] irq_idx;
   logic       irq_valid;

   logic       dispatching;
   logic       clear_cycle;
   logic       sel_valid;
   logic [2:0] sel_idx;
   logic [4:0] sel_oh;

   assign pending = ie_i & if_i;

   gb_cpu_irq_priority u_priority (
      .pending_i (pending),
      .onehot_o  (irq_oh),
      .index_o   (irq_idx),
      .valid_o   (irq_valid)
   );

   assign dispatching = (state_q == StDispatch);
   assign clear_cycle = dispatching && (cnt_q == IsrClearCycle);

`ifdef GB_CPU_ISR_CANCEL_EN
   // Cycle 4 follows the live request so a cleared IE/IF cancels the service.
   assign sel_valid = clear_cycle ? irq_valid : vec_valid_q;
   assign sel_idx   = clear_cycle ? irq_idx   : vec_idx_q;
   assign sel_oh    = clear_cycle ? irq_oh    : vec_oh_q;
`else
   assign sel_valid = vec_valid_q;
   assign sel_idx   = vec_idx_q;
   assign sel_oh    = vec_oh_q;
`endif

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      ime_d       = ime_q;
      ime_delay_d = ime_delay_q;
      halt_bug_d  = 1'b0;
      vec_idx_d   = vec_idx_q;
      vec_oh_d    = vec_oh_q;
      vec_valid_d = vec_valid_q;

      unique case (state_q)
         StRun: begin
            if (boundary_i) begin
               // The boundary that completes a delayed EI never dispatches.
               if (ime_delay_q) begin
                  ime_d       = 1'b1;
                  ime_delay_d = 1'b0;
               end
               if (ime_q && irq_valid && !ime_delay_q) begin
                  state_d     = StDispatch;
                  cnt_d       = 3'd1;
                  ime_d       = 1'b0;
                  vec_idx_d   = irq_idx;
                  vec_oh_d    = irq_oh;
                  vec_valid_d = 1'b1;
               end else if (halt_i) begin
                  if (ime_q || !irq_valid) state_d = StHalt;
                  else                     halt_bug_d = 1'b1;
               end
               if (ei_i) ime_delay_d = 1'b1;
            end
         end
         StHalt: begin
            if (irq_valid) begin
               if (ime_q) begin
                  state_d     = StDispatch;
                  cnt_d       = 3'd1;
                  ime_d       = 1'b0;
                  vec_idx_d   = irq_idx;
                  vec_oh_d    = irq_oh;
                  vec_valid_d = 1'b1;
               end else begin
                  state_d = StRun;
               end
            end
         end
         StDispatch: begin
            if (cnt_q == IsrClearCycle) begin
               vec_idx_d   = sel_idx;
               vec_oh_d    = sel_oh;
               vec_valid_d = sel_valid;
            end
            if (cnt_q == IsrCycles) begin
               state_d = StRun;
               cnt_d   = 3'd0;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         default: state_d = StRun;
      endcase

      if (reti_i) ime_d = 1'b1;
      if (di_i) begin
         ime_d       = 1'b0;
         ime_delay_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StRun;
         cnt_q       <= 3'd0;
         ime_q       <= 1'b0;
         ime_delay_q <= 1'b0;
         halt_bug_q  <= 1'b0;
         vec_idx_q   <= 3'd0;
         vec_oh_q    <= 5'd0;
         vec_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         ime_q       <= ime_d;
         ime_delay_q <= ime_delay_d;
         halt_bug_q  <= halt_bug_d;
         vec_idx_q   <= vec_idx_d;
         vec_oh_q    <= vec_oh_d;
         vec_valid_q <= vec_valid_d;
      end
   end

   always_comb begin
      ime_o            = ime_q;
      dispatch_o       = dispatching;
      dispatch_cycle_o = dispatching ? cnt_q : 3'd0;
      isr_vector_o     = (dispatching && sel_valid) ? isr_vector(sel_idx) : 8'h00;
      if_clear_o       = (clear_cycle && sel_valid) ? sel_oh : 5'd0;
      halted_o         = (state_q == StHalt);
      halt_bug_o       = halt_bug_q;
   end

endmodule
